back_tile_fetch: RTL
====================

Name: back_tile_fetch

Overview:
- Upstream feeder for the background tile draw stage.
- Takes the 8-bit background tile index chosen from the name table and fetches that tile's 128-bit pattern (two 64-bit bit-planes) from a 32-bit-wide pattern ROM in four beats.
- Presents the 128-bit pattern as a stable, atomically-updated register.
- A one-entry tag skips refetch when the index has not changed, which is the common case across the 8 pixels of a tile row.

Parameters:
- IDX_BIT, 8, tile index width.
- ROM_DW, 32, pattern ROM data width; fixed at 32, 128/ROM_DW = 4 beats.
- ROM_AW, 10, pattern ROM address width = IDX_BIT + 2.

Ports:
- clk  in  1  system clock (fast PPU domain).
- rst  in  1  asynchronous, active-high reset.
- tileIndex  in  IDX_BIT  requested background tile index.
- tileReq  in  1  request strobe; tileIndex sampled when high.
- romAddr  out  ROM_AW  pattern ROM word address {index, beat[1:0]}.
- romRd  out  1  ROM read enable; data returns exactly 1 cycle later.
- romData  in  ROM_DW  ROM read data.
- tileData  out  128  assembled pattern to the draw stage; bits[127:64] plane 1, [63:0] plane 0.
- tileValid  out  1  tileData corresponds to tileTag.
- tileTag  out  IDX_BIT  index whose pattern currently sits in tileData.
- busy  out  1  fetch in progress.

Behaviour:
- Reset (async, rst=1) clears everything: tileData=0, tileValid=0, tileTag=0, busy=0, romRd=0, romAddr=0, and the pending flag. FSM goes to IDLE.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On tileReq with (tileValid=1 && tileIndex==tileTag): hit, no action.
  - Otherwise: latch curIdx=tileIndex, beat=0, go to ISSUE.
- ISSUE, beats 0..3 on consecutive cycles:
  - romRd=1, romAddr={curIdx,beat}, beat increments each cycle.
  - After beat 3 is issued, go to DRAIN.
- Data capture:
  - Word returned for beat b (one cycle after issue) goes to a shadow register.
  - Beat 0 → [127:96], beat 1 → [95:64], beat 2 → [63:32], beat 3 → [31:0].
- DRAIN (one cycle):
  - Capture beat 3, then on the same edge copy shadow→tileData, set tileTag=curIdx and tileValid=1.
  - If the pending flag is set, start a new fetch from pendIdx (go straight to ISSUE, beat=0, clear pending). Else go to IDLE.
- Miss latency: 5 cycles from the tileReq edge to tileValid/tileTag update (4 issue + 1 drain). tileData never shows a partially assembled pattern.
- tileReq while busy:
  - If tileIndex == curIdx, ignore it.
  - Otherwise latch pendIdx=tileIndex and set pending. Latest request wins; earlier pending requests are overwritten.
  - A pending index equal to the just-completed curIdx is discarded in DRAIN and no refetch happens.
- busy=1 in ISSUE and DRAIN, 0 in IDLE.
- tileValid only goes 0 at reset. During a fetch the old pattern/tag stay visible and valid.
- rst asserted mid-fetch aborts immediately: romRd=0 the same instant, and no stale write occurs after release.
- romAddr holds its last value when romRd=0.
- Index 0xFF is valid; no wrap special case. romAddr for index 0xFF beat 3 = 10'h3FF.

Test Plan:
- Reset then tileReq with tileIndex=8'h05 → romRd for 4 cycles, addr 0x014..0x017. ROM words A0,A1,A2,A3 → on cycle 5 tileData={A0,A1,A2,A3}, tileTag=5, tileValid=1, busy=0.
- After the previous case, tileReq=1 with index 5 held for 8 cycles → romRd never asserted, tileData unchanged.
- Request 0x10; during ISSUE beat 1 request 0x20, then 0x30 at beat 2 → 0x10 completes, then exactly one fetch for 0x30 (addr 0x0C0..0x0C3); 0x20 is never fetched.
- Request 0x11; during its fetch request 0x22 then 0x11 → 0x11 completes; pending 0x22 is still fetched, because the 0x11 re-request is ignored and does not overwrite pending.
- Request 0xFF → addresses 0x3FC..0x3FF, tileTag=0xFF.
- Assert rst at ISSUE beat 2 of index 0x07, release 3 cycles later → tileValid=0, tileData=0, no romRd after rst. Next request 0x07 does a full fetch (no false hit).

Source files
------------

// File: rtl/back_tile_fetch.sv
// Background tile pattern fetcher: reads four 32-bit ROM beats per tile index,
// assembles them into a shadow register and publishes the 128-bit pattern atomically.
module back_tile_fetch #(
  parameter int unsigned IDX_BIT = 8,
  parameter int unsigned ROM_DW  = 32,
  parameter int unsigned ROM_AW  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_BIT-1:0]    tileIndex,
  input  logic                  tileReq,
  output logic [ROM_AW-1:0]     romAddr,
  output logic                  romRd,
  input  logic [ROM_DW-1:0]     romData,
  output logic [4*ROM_DW-1:0]   tileData,
  output logic                  tileValid,
  output logic [IDX_BIT-1:0]    tileTag,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t               r_state;
  state_t               w_nextState;

  logic [IDX_BIT-1:0]   r_curIdx;
  logic [1:0]           r_beat;
  logic                 r_pend;
  logic [IDX_BIT-1:0]   r_pendIdx;
  logic                 r_romRd;
  logic [ROM_AW-1:0]    r_romAddr;
  logic                 r_capVld;
  logic [1:0]           r_capBeat;
  logic [4*ROM_DW-1:0]  r_shadow;
  logic [4*ROM_DW-1:0]  r_tileData;
  logic                 r_tileValid;
  logic [IDX_BIT-1:0]   r_tileTag;

  logic                 w_hit;
  logic                 w_reqNew;
  logic                 w_start;
  logic [IDX_BIT-1:0]   w_startIdx;
  logic                 w_commit;
  logic                 w_pendVld;
  logic [IDX_BIT-1:0]   w_pendIdx;
  logic [4*ROM_DW-1:0]  w_shadowNext;

  assign w_hit    = r_tileValid && (tileIndex == r_tileTag);
  assign w_reqNew = tileReq && (tileIndex != r_curIdx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A request arriving on the DRAIN edge is folded into the pending slot
  // before deciding whether to chain straight into another fetch.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_startIdx  = r_curIdx;
    w_commit    = 1'b0;
    w_pendVld   = r_pend;
    w_pendIdx   = r_pendIdx;
    if ((r_state != S_IDLE) && w_reqNew) begin
      w_pendVld = 1'b1;
      w_pendIdx = tileIndex;
    end
    case (r_state)
      S_IDLE: begin
        if (tileReq && !w_hit) begin
          w_start     = 1'b1;
          w_startIdx  = tileIndex;
          w_nextState = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_beat == 2'd3) begin
          w_nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_commit = 1'b1;
        if (w_pendVld && (w_pendIdx != r_curIdx)) begin
          w_start     = 1'b1;
          w_startIdx  = w_pendIdx;
          w_nextState = S_ISSUE;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Beat b lands in the b-th 32-bit slot counting down from the MSB.
  always_comb begin
    w_shadowNext = r_shadow;
    if (r_capVld) begin
      case (r_capBeat)
        2'd0:    w_shadowNext[4*ROM_DW-1 -: ROM_DW] = romData;
        2'd1:    w_shadowNext[3*ROM_DW-1 -: ROM_DW] = romData;
        2'd2:    w_shadowNext[2*ROM_DW-1 -: ROM_DW] = romData;
        default: w_shadowNext[ROM_DW-1   -: ROM_DW] = romData;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_curIdx  <= '0;
      r_beat    <= '0;
      r_romRd   <= 1'b0;
      r_romAddr <= '0;
    end else if (w_start) begin
      r_curIdx  <= w_startIdx;
      r_beat    <= 2'd0;
      r_romRd   <= 1'b1;
      r_romAddr <= {w_startIdx, 2'd0};
    end else if (r_state == S_ISSUE) begin
      if (r_beat == 2'd3) begin
        r_romRd <= 1'b0;
      end else begin
        r_beat    <= r_beat + 2'd1;
        r_romAddr <= {r_curIdx, r_beat + 2'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend    <= 1'b0;
      r_pendIdx <= '0;
    end else if (w_commit) begin
      r_pend    <= 1'b0;
      r_pendIdx <= w_pendIdx;
    end else begin
      r_pend    <= w_pendVld;
      r_pendIdx <= w_pendIdx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_capVld  <= 1'b0;
      r_capBeat <= '0;
      r_shadow  <= '0;
    end else begin
      r_capVld  <= r_romRd;
      r_capBeat <= r_beat;
      if (r_capVld) begin
        r_shadow <= w_shadowNext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tileData  <= '0;
      r_tileValid <= 1'b0;
      r_tileTag   <= '0;
    end else if (w_commit) begin
      r_tileData  <= w_shadowNext;
      r_tileValid <= 1'b1;
      r_tileTag   <= r_curIdx;
    end
  end

  assign romRd     = r_romRd;
  assign romAddr   = r_romAddr;
  assign tileData  = r_tileData;
  assign tileValid = r_tileValid;
  assign tileTag   = r_tileTag;
  assign busy      = (r_state != S_IDLE);

endmodule
